// File: rtl/uart_pkg.sv
// uart_pkg
// Shared types and helpers for the parametrised UART blocks.
//   parity_e   : parity selection encoding used by the PARITY parameter.
//   tx_state_e : transmitter FSM state encoding.
//   frame_len  : length of one frame in serial bit periods.
package uart_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } tx_state_e;

    // Bit periods per frame: start + payload + optional parity + stop bits.
    function automatic int frame_len(input int data_w, input int parity, input int stop_bits);
        return 1 + data_w + ((parity != 0) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if
// Host-side bundle of the UART transmitter.
//   ready     : start request, rising edge requests one frame (host -> tx)
//   tx_data   : word sampled on the ready rising edge (host -> tx)
//   tx        : serial line, idles high (tx -> host/pin)
//   busy      : frame on the line
//   hold_full : holding register occupied
//   tx_done   : one-cycle pulse on the last cycle of the final stop bit
//   overrun   : one-cycle pulse when a request is dropped
interface uart_tx_param_if #(
    parameter int IN_W = 16
);
    logic            ready;
    logic [IN_W-1:0] tx_data;
    logic            tx;
    logic            busy;
    logic            hold_full;
    logic            tx_done;
    logic            overrun;

    modport master (
        output ready, tx_data,
        input  tx, busy, hold_full, tx_done, overrun
    );

    modport slave (
        input  ready, tx_data,
        output tx, busy, hold_full, tx_done, overrun
    );
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle.
//   clk     : system clock
//   clr     : synchronous active-high reset
//   restart : synchronous counter clear (held while the owner is idle)
//   bit_end : high on the last cycle of each bit period
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic clr,
    input  logic restart,
    output logic bit_end
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (clr || restart) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_end = (cnt == CNT_LAST);
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param
// Parametrised UART transmitter with a one-word holding buffer.
//   clk : system clock
//   clr : synchronous active-high reset, aborts any frame and empties the hold
//   bus : uart_tx_param_if slave port (ready/tx_data in; tx, busy,
//         hold_full, tx_done, overrun out)
// Frame: start(0), DATA_W bits LSB first, optional parity, STOP_BITS stop(1).
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int IN_W         = 16
) (
    input logic          clk,
    input logic          clr,
    uart_tx_param_if.slave bus
);
    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_START = START;
    localparam logic [2:0] S_DATA  = DATA;
    localparam logic [2:0] S_PAR   = PAR;
    localparam logic [2:0] S_STOP  = STOP;

    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_W - 1);
    localparam logic [1:0]       LAST_STOP = 2'(STOP_BITS - 1);
    localparam logic             HAS_PAR   = (PARITY != int'(NONE));
    localparam logic             ODD_FLAG  = (PARITY == int'(ODD));

    logic [2:0]        state;
    logic              ready_q;
    logic              hold_full;
    logic              busy;
    logic              tx;
    logic              overrun;
    logic [IDX_W-1:0]  bit_idx;
    logic [1:0]        stop_idx;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] shreg;
    logic              par_bit;

    logic bit_end;
    logic req;
    logic frame_end;
    logic load;
    logic take;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .clr    (clr),
        .restart(state == S_IDLE),
        .bit_end(bit_end)
    );

    assign req       = bus.ready & ~ready_q;
    assign frame_end = (state == S_STOP) && bit_end && (stop_idx == LAST_STOP);
    // The hold moves into the shift register either from idle or straight out
    // of the final stop bit, which is what gives zero-gap back-to-back frames.
    assign load      = hold_full && ((state == S_IDLE) || frame_end);
    // A request is accepted if the hold is empty or is being emptied this cycle.
    assign take      = req && (!hold_full || load);

    // Control path: FSM, flags and serial line.
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= S_IDLE;
            ready_q   <= 1'b0;
            hold_full <= 1'b0;
            busy      <= 1'b0;
            tx        <= 1'b1;
            overrun   <= 1'b0;
            bit_idx   <= '0;
            stop_idx  <= '0;
        end else begin
            ready_q <= bus.ready;
            overrun <= req && !take;

            if (take) begin
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (hold_full) begin
                        state <= S_START;
                        busy  <= 1'b1;
                        tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state   <= S_DATA;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == LAST_IDX) begin
                            if (HAS_PAR) begin
                                state <= S_PAR;
                                tx    <= par_bit;
                            end else begin
                                state    <= S_STOP;
                                stop_idx <= '0;
                                tx       <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shreg[1];
                        end
                    end
                end
                S_PAR: begin
                    if (bit_end) begin
                        state    <= S_STOP;
                        stop_idx <= '0;
                        tx       <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (stop_idx == LAST_STOP) begin
                            if (hold_full) begin
                                state <= S_START;
                                tx    <= 1'b0;
                            end else begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            stop_idx <= stop_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    // Data path: hold and shift registers carry no reset; hold_full and the
    // FSM decide when their contents are meaningful.
    always_ff @(posedge clk) begin
        if (take) begin
            hold <= bus.tx_data[DATA_W-1:0];
        end
        if (load) begin
            shreg   <= hold;
            par_bit <= (^hold) ^ ODD_FLAG;
        end else if ((state == S_DATA) && bit_end) begin
            shreg <= shreg >> 1;
        end
    end

    assign bus.tx        = tx;
    assign bus.busy      = busy;
    assign bus.hold_full = hold_full;
    assign bus.tx_done   = frame_end;
    assign bus.overrun   = overrun;
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param
// Bench for uart_tx_param with two configurations sharing clk/clr:
//   dut_a : DATA_W=8, CLKS_PER_BIT=4, even parity, 1 stop bit
//   dut_b : DATA_W=8, CLKS_PER_BIT=4, odd parity,  2 stop bits
// Expected line waveforms come from a frame model built from the bit rules.
module tb_uart_tx_param;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    uart_tx_param_if #(.IN_W(16)) ifa ();
    uart_tx_param_if #(.IN_W(16)) ifb ();

    uart_tx_param #(
        .DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1), .IN_W(16)
    ) dut_a (
        .clk(clk), .clr(clr), .bus(ifa.slave)
    );

    uart_tx_param #(
        .DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2), .IN_W(16)
    ) dut_b (
        .clk(clk), .clr(clr), .bus(ifb.slave)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic drive(input int which, input logic rdy, input logic [15:0] w);
        if (which == 0) begin
            ifa.ready   = rdy;
            ifa.tx_data = w;
        end else begin
            ifb.ready   = rdy;
            ifb.tx_data = w;
        end
    endtask

    function automatic logic obs_tx(input int which);
        return (which == 0) ? ifa.tx : ifb.tx;
    endfunction
    function automatic logic obs_busy(input int which);
        return (which == 0) ? ifa.busy : ifb.busy;
    endfunction
    function automatic logic obs_done(input int which);
        return (which == 0) ? ifa.tx_done : ifb.tx_done;
    endfunction
    function automatic logic obs_hold(input int which);
        return (which == 0) ? ifa.hold_full : ifb.hold_full;
    endfunction
    function automatic logic obs_ovr(input int which);
        return (which == 0) ? ifa.overrun : ifb.overrun;
    endfunction

    // Raise ready with a word on the next negedge; the following posedge is the request edge.
    task automatic request(input int which, input logic [15:0] w);
        @(negedge clk);
        drive(which, 1'b1, w);
    endtask

    // Expects the first start-bit cycle at the next negedge, checks every
    // cycle of one frame against the model waveform.
    task automatic check_frame(input int which, input logic [15:0] w, input string name);
        int   par   = (which == 0) ? 1 : 2;
        int   stops = (which == 0) ? 1 : 2;
        logic [7:0] payload = w[7:0];
        bit   exp_q[$];
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(payload[i]);
        if (par != 0) exp_q.push_back(1'(($countones(payload) % 2) ^ (par == 2 ? 1 : 0)));
        for (int i = 0; i < stops; i++) exp_q.push_back(1'b1);
        for (int b = 0; b < exp_q.size(); b++) begin
            for (int c = 0; c < CPB; c++) begin
                logic last = (b == exp_q.size() - 1) && (c == CPB - 1);
                @(negedge clk);
                total++;
                if (obs_tx(which) !== exp_q[b]) begin
                    bad++;
                    $display("FAIL %s tx bit%0d cyc%0d: got=%b want=%b", name, b, c, obs_tx(which), exp_q[b]);
                end
                total++;
                if (obs_done(which) !== last) begin
                    bad++;
                    $display("FAIL %s tx_done bit%0d cyc%0d: got=%b want=%b", name, b, c, obs_done(which), last);
                end
                total++;
                if (obs_busy(which) !== 1'b1) begin
                    bad++;
                    $display("FAIL %s busy bit%0d cyc%0d: got=%b want=1", name, b, c, obs_busy(which));
                end
            end
        end
    endtask

    // Request a frame from idle, check acceptance, the full waveform and the return to idle.
    task automatic single_frame(input int which, input logic [15:0] w, input string name);
        request(which, w);
        @(negedge clk);
        total++;
        if (obs_hold(which) !== 1'b1 || obs_busy(which) !== 1'b0) begin
            bad++;
            $display("FAIL %s accept: got hold=%b busy=%b want hold=1 busy=0", name, obs_hold(which), obs_busy(which));
        end
        drive(which, 1'b0, w);
        check_frame(which, w, name);
        @(negedge clk);
        total++;
        if (obs_busy(which) !== 1'b0 || obs_tx(which) !== 1'b1 || obs_hold(which) !== 1'b0) begin
            bad++;
            $display("FAIL %s idle after: got busy=%b tx=%b hold=%b want 0/1/0", name, obs_busy(which), obs_tx(which), obs_hold(which));
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs_tx(k) !== 1'b1 || obs_busy(k) !== 1'b0 || obs_hold(k) !== 1'b0 ||
                obs_done(k) !== 1'b0 || obs_ovr(k) !== 1'b0) begin
                bad++;
                $display("FAIL reset_state dut%0d: got tx=%b busy=%b hold=%b done=%b ovr=%b want 1/0/0/0/0",
                         k, obs_tx(k), obs_busy(k), obs_hold(k), obs_done(k), obs_ovr(k));
            end
        end
        clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        single_frame(0, 16'h00A5, "basic_a5");
    endtask

    task automatic test_parity_stop();
        single_frame(1, 16'h0007, "odd_2stop_07");
        single_frame(0, 16'h0007, "even_07");
    endtask

    task automatic test_truncation();
        single_frame(0, 16'h1234, "trunc_1234");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) single_frame(0, 16'($urandom), "rand_a");
        for (int i = 0; i < 3; i++) single_frame(1, 16'($urandom), "rand_b");
    endtask

    task automatic test_back_to_back();
        int busy_cnt = 0;
        request(0, 16'h0011);
        @(negedge clk);
        drive(0, 1'b0, 16'h0011);
        fork
            begin
                check_frame(0, 16'h0011, "b2b_first");
                check_frame(0, 16'h0022, "b2b_second");
            end
            begin
                repeat (10) @(negedge clk);
                drive(0, 1'b1, 16'h0022);
                @(negedge clk);
                total++;
                if (ifa.hold_full !== 1'b1 || ifa.overrun !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_hold: got hold=%b ovr=%b want hold=1 ovr=0", ifa.hold_full, ifa.overrun);
                end
                drive(0, 1'b0, 16'h0022);
                repeat (5) @(negedge clk);
                drive(0, 1'b1, 16'h0033);
                @(negedge clk);
                total++;
                if (ifa.overrun !== 1'b1) begin
                    bad++;
                    $display("FAIL overrun_pulse: got=%b want=1", ifa.overrun);
                end
                drive(0, 1'b0, 16'h0033);
                @(negedge clk);
                total++;
                if (ifa.overrun !== 1'b0 || ifa.hold_full !== 1'b1) begin
                    bad++;
                    $display("FAIL overrun_once: got ovr=%b hold=%b want ovr=0 hold=1", ifa.overrun, ifa.hold_full);
                end
            end
        join
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ifa.busy === 1'b1) busy_cnt++;
        end
        total++;
        if (busy_cnt != 0) begin
            bad++;
            $display("FAIL b2b_no_third_frame: got busy_cycles=%0d want=0", busy_cnt);
        end
    endtask

    task automatic test_level_held();
        int done_cnt = 0;
        request(0, 16'h005A);
        for (int i = 0; i < 190; i++) begin
            @(negedge clk);
            if (ifa.tx_done === 1'b1) done_cnt++;
        end
        drive(0, 1'b0, 16'h005A);
        total++;
        if (done_cnt != 1) begin
            bad++;
            $display("FAIL level_held_done_count: got=%0d want=1", done_cnt);
        end
        @(negedge clk);
        total++;
        if (ifa.busy !== 1'b0 || ifa.hold_full !== 1'b0) begin
            bad++;
            $display("FAIL level_held_idle: got busy=%b hold=%b want 0/0", ifa.busy, ifa.hold_full);
        end
    endtask

    task automatic test_reset_mid_frame();
        int busy_cnt = 0;
        request(0, 16'h00C3);
        @(negedge clk);
        drive(0, 1'b0, 16'h00C3);
        repeat (2) @(negedge clk);
        drive(0, 1'b1, 16'h0099);
        @(negedge clk);
        total++;
        if (ifa.hold_full !== 1'b1) begin
            bad++;
            $display("FAIL midreset_hold_loaded: got=%b want=1", ifa.hold_full);
        end
        drive(0, 1'b0, 16'h0099);
        // Now at frame cycle 3; data bit 3 spans cycles 17..20.
        repeat (15) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        total++;
        if (ifa.tx !== 1'b1 || ifa.busy !== 1'b0 || ifa.hold_full !== 1'b0 || ifa.tx_done !== 1'b0) begin
            bad++;
            $display("FAIL midreset_state: got tx=%b busy=%b hold=%b done=%b want 1/0/0/0",
                     ifa.tx, ifa.busy, ifa.hold_full, ifa.tx_done);
        end
        clr = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ifa.busy === 1'b1 || ifa.tx_done === 1'b1) busy_cnt++;
        end
        total++;
        if (busy_cnt != 0) begin
            bad++;
            $display("FAIL midreset_hold_discarded: got active_cycles=%0d want=0", busy_cnt);
        end
        single_frame(0, 16'h003C, "after_reset_3c");
    endtask

    initial begin
        drive(0, 1'b0, 16'h0000);
        drive(1, 1'b0, 16'h0000);
        test_reset();
        test_basic();
        test_parity_stop();
        test_truncation();
        test_random();
        test_back_to_back();
        test_level_held();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
